cache_dir_arbiter: RTL and testbench

Arbitrates shared access to one cache directory port (a `cache_dir_if` `req` modport) among NUM_REQ requesters, e.g. the core-side cache controller and the snoop/coherence engine. Each granted transaction is sequenced as accept, one directory access cycle, then a held response. Each transaction performs a lookup and an optional state write. A requester can lock the directory across several transactions so that a read-then-update sequence is atomic. The block sits between the cache controllers and the directory and owns all drive of the directory's `addr`/`next_state`/`write`.

---
 rtl/cache_dir_arbiter_if.sv | 26 ++
 rtl/cache_dir_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_dir_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_dir_arbiter_if.sv
// Directory port shared by the arbiter and the cache directory, plus the line-state encoding.
package cache_dir_pkg;
    typedef enum logic [1:0] {
        LS_I = 2'd0,
        LS_S = 2'd1,
        LS_E = 2'd2,
        LS_M = 2'd3
    } line_state_t;
endpackage

interface cache_dir_if #(
    parameter int ADDR_WIDTH = 32
);
    import cache_dir_pkg::*;

    logic [ADDR_WIDTH-1:0] addr;
    line_state_t           next_state;
    logic                  write;
    logic                  hit;
    line_state_t           current_state;

    // Arbiter side: drives lookup address and optional state update.
    modport req (output addr, next_state, write, input hit, current_state);
    // Directory side: answers the lookup combinationally, updates on write.
    modport dir (input addr, next_state, write, output hit, current_state);
endinterface

// File: rtl/cache_dir_arbiter.sv
// Round-robin arbiter for a single cache directory port with per-requester lock.
// Each grant runs accept -> one ACCESS cycle -> held RESP; LOCKED keeps the
// grant with the same requester across transactions.
module cache_dir_arbiter
    import cache_dir_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic        [NUM_REQ-1:0]           req_valid,
    output logic        [NUM_REQ-1:0]           req_ready,
    input  logic        [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic        [NUM_REQ-1:0]           req_write,
    input  line_state_t [NUM_REQ-1:0]           req_next_state,
    input  logic        [NUM_REQ-1:0]           req_lock,
    output logic        [NUM_REQ-1:0]           rsp_valid,
    input  logic        [NUM_REQ-1:0]           rsp_ready,
    output logic                                rsp_hit,
    output line_state_t                         rsp_state,
    cache_dir_if.req                            dir
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, LOCKED} state_t;

    state_t                r_state, w_next;
    logic [IDW-1:0]        r_ptr, r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write, r_lock;
    line_state_t           r_ns;
    logic                  r_hit;
    line_state_t           r_rsp_state;

    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [IDW-1:0]        w_sel;
    logic                  w_accept;

    // (base + off) mod NUM_REQ for off in [0, NUM_REQ).
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Round-robin pick: scanning offsets high to low so the smallest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_ptr, i);
            end
        end
    end

    // In LOCKED only the lock owner can be accepted; otherwise the RR winner.
    assign w_sel = (r_state == LOCKED) ? r_id : w_win;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    req_ready[w_win] = 1'b1;
                    w_accept         = 1'b1;
                    w_next           = ACCESS;
                end
            end
            ACCESS: w_next = RESP;
            RESP: begin
                rsp_valid[r_id] = 1'b1;
                if (rsp_ready[r_id]) w_next = r_lock ? LOCKED : IDLE;
            end
            LOCKED: begin
                if (req_valid[r_id]) begin
                    req_ready[r_id] = 1'b1;
                    w_accept        = 1'b1;
                    w_next          = ACCESS;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Payload latch on accept, RR pointer advance on unlocked grants only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_lock  <= 1'b0;
            r_ns    <= LS_I;
        end else if (w_accept) begin
            r_id    <= w_sel;
            r_addr  <= req_addr[w_sel];
            r_write <= req_write[w_sel];
            r_lock  <= req_lock[w_sel];
            r_ns    <= req_next_state[w_sel];
            if (r_state == IDLE) r_ptr <= wrap_add(w_win, 1);
        end
    end

    // Capture the pre-write lookup result during ACCESS; held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit       <= 1'b0;
            r_rsp_state <= LS_I;
        end else if (r_state == ACCESS) begin
            r_hit       <= dir.hit;
            r_rsp_state <= dir.current_state;
        end
    end

    assign rsp_hit        = r_hit;
    assign rsp_state      = r_rsp_state;

    // Write strobe decoded from state so an async reset drops it immediately.
    assign dir.addr       = r_addr;
    assign dir.next_state = r_ns;
    assign dir.write      = (r_state == ACCESS) && r_write;

endmodule

// File: tb/tb_cache_dir_arbiter.sv
// Directed bench for cache_dir_arbiter: vector table plus lock, backpressure,
// async-reset and round-robin-from-reset sequences against a small directory model.
module tb_cache_dir_arbiter;
    import cache_dir_pkg::*;

    logic clk;
    logic rst_n;
    logic dinit;
    logic        [1:0]       req_valid, req_ready, req_write, req_lock;
    logic        [1:0][31:0] req_addr;
    line_state_t [1:0]       req_next_state;
    logic        [1:0]       rsp_valid, rsp_ready;
    logic                    rsp_hit;
    line_state_t             rsp_state;

    int n_cmp = 0;
    int n_err = 0;

    cache_dir_if #(.ADDR_WIDTH(32)) dif ();

    cache_dir_arbiter #(.ADDR_WIDTH(32), .NUM_REQ(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_next_state (req_next_state),
        .req_lock       (req_lock),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_hit        (rsp_hit),
        .rsp_state      (rsp_state),
        .dir            (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three-entry directory: 0x1000=S, 0x2040=S, 0x3000=E; anything else misses.
    localparam logic [31:0] TAGS [3] = '{32'h1000, 32'h2040, 32'h3000};
    line_state_t dst [3];

    always_comb begin
        dif.hit           = 1'b0;
        dif.current_state = LS_I;
        for (int k = 0; k < 3; k++) begin
            if (dif.addr == TAGS[k]) begin
                dif.hit           = 1'b1;
                dif.current_state = dst[k];
            end
        end
    end

    always @(posedge clk) begin
        if (dinit) begin
            dst[0] <= LS_S;
            dst[1] <= LS_S;
            dst[2] <= LS_E;
        end else if (dif.write) begin
            for (int k = 0; k < 3; k++)
                if (dif.addr == TAGS[k]) dst[k] <= dif.next_state;
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, a1;
        logic [1:0]  w;
        line_state_t ns1;
        logic [1:0]  lk;
        logic [1:0]  rdy, rv;
        logic        hit;
        line_state_t st;
        logic        dw;
        logic [31:0] da;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [1:0] w, input line_state_t ns1, input logic [1:0] lk,
                                input logic [1:0] rdy, input logic [1:0] rv, input logic hit,
                                input line_state_t st, input logic dw, input logic [31:0] da);
        vec_t r;
        r.v = v; r.a0 = a0; r.a1 = a1; r.w = w; r.ns1 = ns1; r.lk = lk;
        r.rdy = rdy; r.rv = rv; r.hit = hit; r.st = st; r.dw = dw; r.da = da;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [1:0] w, input line_state_t ns1, input logic [1:0] lk,
                         input logic [1:0] rr);
        req_valid         = v;
        req_addr[0]       = a0;
        req_addr[1]       = a1;
        req_write         = w;
        req_next_state[0] = LS_I;
        req_next_state[1] = ns1;
        req_lock          = lk;
        rsp_ready         = rr;
    endtask

    // Drive at posedge+1, sample at the following negedge.
    task automatic cyc(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] w, input line_state_t ns1, input logic [1:0] lk,
                       input logic [1:0] rr);
        @(posedge clk);
        #1;
        drive(v, a0, a1, w, ns1, lk, rr);
        @(negedge clk);
    endtask

    vec_t vecs [22];

    initial begin
        rst_n = 1'b0;
        dinit = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 2'b00, LS_I, 2'b00, 2'b11);

        vecs[0]  = mk(2'b01, 32'h1000, 32'h0,    2'b00, LS_I, 2'b00, 2'b01, 2'b00, 1'b0, LS_I, 1'b0, 32'h0);
        vecs[1]  = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b0, LS_I, 1'b0, 32'h1000);
        vecs[2]  = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b01, 1'b1, LS_S, 1'b0, 32'h1000);
        vecs[3]  = mk(2'b10, 32'h0,    32'h2040, 2'b10, LS_M, 2'b00, 2'b10, 2'b00, 1'b1, LS_S, 1'b0, 32'h1000);
        vecs[4]  = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b1, LS_S, 1'b1, 32'h2040);
        vecs[5]  = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b10, 1'b1, LS_S, 1'b0, 32'h2040);
        vecs[6]  = mk(2'b01, 32'h2040, 32'h0,    2'b00, LS_I, 2'b00, 2'b01, 2'b00, 1'b1, LS_S, 1'b0, 32'h2040);
        vecs[7]  = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b1, LS_S, 1'b0, 32'h2040);
        vecs[8]  = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b01, 1'b1, LS_M, 1'b0, 32'h2040);
        vecs[9]  = mk(2'b01, 32'h5000, 32'h0,    2'b00, LS_I, 2'b00, 2'b01, 2'b00, 1'b1, LS_M, 1'b0, 32'h2040);
        vecs[10] = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b1, LS_M, 1'b0, 32'h5000);
        vecs[11] = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b01, 1'b0, LS_I, 1'b0, 32'h5000);
        vecs[12] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b10, 2'b00, 1'b0, LS_I, 1'b0, 32'h5000);
        vecs[13] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b0, LS_I, 1'b0, 32'h3000);
        vecs[14] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b00, 2'b10, 1'b1, LS_E, 1'b0, 32'h3000);
        vecs[15] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b01, 2'b00, 1'b1, LS_E, 1'b0, 32'h3000);
        vecs[16] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b1, LS_E, 1'b0, 32'h1000);
        vecs[17] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b00, 2'b01, 1'b1, LS_S, 1'b0, 32'h1000);
        vecs[18] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b10, 2'b00, 1'b1, LS_S, 1'b0, 32'h1000);
        vecs[19] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b1, LS_S, 1'b0, 32'h3000);
        vecs[20] = mk(2'b11, 32'h1000, 32'h3000, 2'b00, LS_I, 2'b00, 2'b00, 2'b10, 1'b1, LS_E, 1'b0, 32'h3000);
        vecs[21] = mk(2'b00, 32'h0,    32'h0,    2'b00, LS_I, 2'b00, 2'b00, 2'b00, 1'b1, LS_E, 1'b0, 32'h3000);

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_hit", 32'(rsp_hit), 32'h0);
        chk("reset rsp_state", 32'(rsp_state), 32'h0);
        chk("reset dir_write", 32'(dif.write), 32'h0);
        chk("reset dir_addr", dif.addr, 32'h0);
        chk("reset dir_next_state", 32'(dif.next_state), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        dinit = 1'b0;

        // Vector table: read, write, read-back, miss, round-robin.
        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].w, vecs[i].ns1, vecs[i].lk, 2'b11);
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
            chk($sformatf("row%0d rsp_hit", i), 32'(rsp_hit), 32'(vecs[i].hit));
            chk($sformatf("row%0d rsp_state", i), 32'(rsp_state), 32'(vecs[i].st));
            chk($sformatf("row%0d dir_write", i), 32'(dif.write), 32'(vecs[i].dw));
            chk($sformatf("row%0d dir_addr", i), dif.addr, vecs[i].da);
        end

        // Lock: requester 1 read(lock=1) then write(lock=0); requester 0 waits.
        cyc(2'b10, 32'h1000, 32'h2040, 2'b00, LS_I, 2'b10, 2'b11);
        chk("lock c0 req_ready", 32'(req_ready), 32'h2);
        cyc(2'b11, 32'h1000, 32'h2040, 2'b00, LS_I, 2'b00, 2'b11);
        chk("lock c1 req_ready", 32'(req_ready), 32'h0);
        cyc(2'b11, 32'h1000, 32'h2040, 2'b00, LS_I, 2'b00, 2'b11);
        chk("lock c2 rsp_valid", 32'(rsp_valid), 32'h2);
        chk("lock c2 rsp_state", 32'(rsp_state), 32'(LS_M));
        chk("lock c2 req_ready", 32'(req_ready), 32'h0);
        cyc(2'b11, 32'h1000, 32'h2040, 2'b10, LS_E, 2'b00, 2'b11);
        chk("lock c3 req_ready", 32'(req_ready), 32'h2);
        cyc(2'b11, 32'h1000, 32'h2040, 2'b00, LS_I, 2'b00, 2'b11);
        chk("lock c4 req_ready", 32'(req_ready), 32'h0);
        chk("lock c4 dir_write", 32'(dif.write), 32'h1);
        cyc(2'b11, 32'h1000, 32'h2040, 2'b00, LS_I, 2'b00, 2'b11);
        chk("lock c5 rsp_valid", 32'(rsp_valid), 32'h2);
        chk("lock c5 rsp_state", 32'(rsp_state), 32'(LS_M));
        chk("lock c5 req_ready", 32'(req_ready), 32'h0);
        cyc(2'b01, 32'h2040, 32'h0, 2'b00, LS_I, 2'b00, 2'b11);
        chk("lock c6 req_ready", 32'(req_ready), 32'h1);
        cyc(2'b00, 32'h2040, 32'h0, 2'b00, LS_I, 2'b00, 2'b11);
        chk("lock c7 req_ready", 32'(req_ready), 32'h0);

        // Response backpressure on requester 0 while requester 1 waits.
        for (int k = 0; k < 5; k++) begin
            cyc(2'b10, 32'h2040, 32'h2040, 2'b10, LS_I, 2'b00, 2'b00);
            chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d rsp_hit", k), 32'(rsp_hit), 32'h1);
            chk($sformatf("bp%0d rsp_state", k), 32'(rsp_state), 32'(LS_E));
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'h0);
        end
        cyc(2'b10, 32'h2040, 32'h2040, 2'b10, LS_I, 2'b00, 2'b01);
        chk("bp hs rsp_valid", 32'(rsp_valid), 32'h1);
        chk("bp hs req_ready", 32'(req_ready), 32'h0);
        cyc(2'b10, 32'h2040, 32'h2040, 2'b10, LS_I, 2'b00, 2'b11);
        chk("bp after req_ready", 32'(req_ready), 32'h2);

        // Async reset during ACCESS of requester 1's write.
        @(posedge clk);
        #1;
        drive(2'b00, 32'h0, 32'h0, 2'b00, LS_I, 2'b00, 2'b11);
        chk("arst pre dir_write", 32'(dif.write), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst dir_write", 32'(dif.write), 32'h0);
        chk("arst req_ready", 32'(req_ready), 32'h0);
        chk("arst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst rsp_hit", 32'(rsp_hit), 32'h0);
        chk("arst rsp_state", 32'(rsp_state), 32'h0);
        chk("arst dir_addr", dif.addr, 32'h0);
        chk("arst dir_next_state", 32'(dif.next_state), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Round-robin from reset: grants 0,1,0,1 every 3 cycles; the first read
        // also shows the abandoned write never reached the directory.
        for (int k = 0; k < 12; k++) begin
            logic [1:0] who;
            who = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            cyc(2'b11, 32'h2040, 32'h3000, 2'b00, LS_I, 2'b00, 2'b11);
            chk($sformatf("rr%0d req_ready", k), 32'(req_ready), (k % 3 == 0) ? 32'(who) : 32'h0);
            chk($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), (k % 3 == 2) ? 32'(who) : 32'h0);
            chk($sformatf("rr%0d dir_write", k), 32'(dif.write), 32'h0);
            if (k == 2 || k == 5) chk($sformatf("rr%0d rsp_state", k), 32'(rsp_state), 32'(LS_E));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
